// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request into one or two word-aligned
// memory accesses, with store lane steering and load merge/extension.
module load_store_unit #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [2:0]   i_mem_type,
    input  logic [N-1:0] i_addr,
    input  logic [N-1:0] i_wdata,
    output logic         o_rsp_valid,
    output logic [N-1:0] o_rsp_rdata,
    output logic         o_rsp_err,
    output logic         o_mem_we,
    output logic         o_mem_re,
    output logic [N-1:0] o_mem_addr,
    output logic [N-1:0] o_mem_wdata,
    output logic [3:0]   o_mem_wstrb,
    input  logic [N-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    // Handshake: a request is taken on a rising edge where i_req_valid and
    // o_req_ready are both high; o_rsp_valid is a single-cycle completion pulse.
    state_t         state;
    logic           we_q;
    logic [2:0]     type_q;
    logic [N-1:0]   addr_q;
    logic [N-1:0]   wdata_q;
    logic [N-1:0]   lo_q;

    logic [2*N-1:0] in_data;
    logic [7:0]     in_mask;
    logic [2*N-1:0] q_data;
    logic [7:0]     q_mask;
    logic [N-1:0]   ld_single;
    logic [N-1:0]   ld_double;

    function automatic logic is_legal(input logic we, input logic [2:0] t);
        case (t)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b100, 3'b101:         is_legal = !we;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] base_mask(input logic [2:0] t);
        case (t[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
    endfunction

    // An access crosses into the next word when offset + size exceeds 4 bytes.
    function automatic logic crosses(input logic [2:0] t, input logic [1:0] off);
        case (t[1:0])
            2'b00:   crosses = 1'b0;
            2'b01:   crosses = (off == 2'd3);
            default: crosses = (off != 2'd0);
        endcase
    endfunction

    function automatic logic [N-1:0] assemble(input logic [2:0] t, input logic [1:0] off,
                                              input logic [N-1:0] hi, input logic [N-1:0] lo);
        logic [2*N-1:0] win;
        win = {hi, lo} >> {off, 3'b000};
        case (t)
            3'b000:  assemble = {{24{win[7]}}, win[7:0]};
            3'b001:  assemble = {{16{win[15]}}, win[15:0]};
            3'b100:  assemble = {24'h0, win[7:0]};
            3'b101:  assemble = {16'h0, win[15:0]};
            default: assemble = win[31:0];
        endcase
    endfunction

    assign in_data   = {{N{1'b0}}, i_wdata} << {i_addr[1:0], 3'b000};
    assign in_mask   = base_mask(i_mem_type) << i_addr[1:0];
    assign q_data    = {{N{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
    assign q_mask    = base_mask(type_q) << addr_q[1:0];
    assign ld_single = assemble(type_q, addr_q[1:0], {N{1'b0}}, i_mem_rdata);
    assign ld_double = assemble(type_q, addr_q[1:0], i_mem_rdata, lo_q);

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            type_q      <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_re    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q        <= i_req_we;
                        type_q      <= i_mem_type;
                        addr_q      <= i_addr;
                        wdata_q     <= i_wdata;
                        o_req_ready <= 1'b0;
                        if (!is_legal(i_req_we, i_mem_type)) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            // First access is presented straight off the accept edge.
                            state       <= ACC0;
                            o_mem_we    <= i_req_we;
                            o_mem_re    <= !i_req_we;
                            o_mem_addr  <= {i_addr[N-1:2], 2'b00};
                            o_mem_wdata <= i_req_we ? in_data[N-1:0] : '0;
                            o_mem_wstrb <= i_req_we ? in_mask[3:0] : 4'b0000;
                        end
                    end
                end
                ACC0: begin
                    if (!we_q) lo_q <= i_mem_rdata;
                    if (crosses(type_q, addr_q[1:0])) begin
                        state       <= ACC1;
                        o_mem_addr  <= o_mem_addr + 32'd4;
                        o_mem_wdata <= we_q ? q_data[2*N-1:N] : '0;
                        o_mem_wstrb <= we_q ? q_mask[7:4] : 4'b0000;
                    end else begin
                        state       <= RESP;
                        o_mem_we    <= 1'b0;
                        o_mem_re    <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        o_mem_wstrb <= 4'b0000;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= we_q ? '0 : ld_single;
                    end
                end
                ACC1: begin
                    state       <= RESP;
                    o_mem_we    <= 1'b0;
                    o_mem_re    <= 1'b0;
                    o_mem_addr  <= '0;
                    o_mem_wdata <= '0;
                    o_mem_wstrb <= 4'b0000;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= we_q ? '0 : ld_double;
                end
                RESP: begin
                    state       <= IDLE;
                    o_rsp_valid <= 1'b0;
                    o_rsp_rdata <= '0;
                    o_rsp_err   <= 1'b0;
                    o_req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard queues for responses and
// memory accesses, checked by monitors independent of the stimulus driver.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  mem_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.N(32)) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_mem_type  (mem_type),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_mem_we    (mem_we),
        .o_mem_re    (mem_re),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wstrb (mem_wstrb),
        .i_mem_rdata (mem_rdata)
    );

    // 16-word memory model; pokes load test patterns while the unit is idle.
    logic [31:0] mem [0:15];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = 4'd0;
    logic [31:0] poke_val = 32'h0;

    assign mem_rdata = mem_re ? mem[mem_addr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Response entry: {latency[1:0], err, rdata}; mem entry: {we, re, addr, wdata, wstrb}.
    logic [34:0] exp_q[$];
    int          acc_q[$];
    logic [69:0] mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [34:0] rsp(input logic [1:0] lat, input logic err, input logic [31:0] d);
        return {lat, err, d};
    endfunction

    function automatic logic [69:0] macc(input logic we, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
        return {we, !we, a, d, s};
    endfunction

    // Response monitor.
    logic [34:0] rsp_e;
    int          rsp_a;
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rdata=%08h err=%0b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                rsp_e = exp_q.pop_front();
                rsp_a = acc_q.pop_front();
                check("rsp_rdata", rsp_rdata, rsp_e[31:0]);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, rsp_e[32]});
                check("rsp_latency", cyc - rsp_a + 1, {30'b0, rsp_e[34:33]});
            end
        end else begin
            check("idle_rdata", rsp_rdata, 32'h0);
            check("idle_err", {31'b0, rsp_err}, 32'h0);
        end
    end

    // Memory access monitor.
    logic [69:0] mem_e;
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            if (mem_we && mem_re) begin
                total++;
                bad++;
                $display("FAIL mem_we_re_both: got both high at addr %08h", mem_addr);
            end
            if (mem_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_mem: got we=%0b re=%0b addr=%08h, none expected", mem_we, mem_re, mem_addr);
            end else begin
                mem_e = mem_q.pop_front();
                check("mem_we", {31'b0, mem_we}, {31'b0, mem_e[69]});
                check("mem_re", {31'b0, mem_re}, {31'b0, mem_e[68]});
                check("mem_addr", mem_addr, mem_e[67:36]);
                if (mem_e[69]) begin
                    check("mem_wdata", mem_wdata, mem_e[35:4]);
                    check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mem_e[3:0]});
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic want_rsp, input logic [34:0] e);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got ready=0 expected 1 within 20 cycles");
        end
        if (want_rsp) exp_q.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        mem_type  = t;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        if (want_rsp) acc_q.push_back(cyc);
        req_valid = 1'b0;
        req_we    = 1'b0;
        mem_type  = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(req_ready && exp_q.size() == 0 && mem_q.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(req_ready && exp_q.size() == 0 && mem_q.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got ready=%0b rsp_pending=%0d mem_pending=%0d expected idle",
                     req_ready, exp_q.size(), mem_q.size());
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
        check({tag, "_mem_re"}, {31'b0, mem_re}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        mem_type  = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        poke(4'd5, 32'h0);

        // Aligned word store then load.
        mem_q.push_back(macc(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111));
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, rsp(2'd2, 1'b0, 32'h0));
        wait_idle();
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rsp(2'd2, 1'b0, 32'hDEADBEEF));
        wait_idle();

        // Byte/half extension from word 0x80FF1234.
        poke(4'd4, 32'h80FF1234);
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, rsp(2'd2, 1'b0, 32'hFFFFFF80));
        wait_idle();
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, rsp(2'd2, 1'b0, 32'h00000080));
        wait_idle();
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, rsp(2'd2, 1'b0, 32'hFFFF80FF));
        wait_idle();

        // Crossing halfword store, then loads of it back.
        mem_q.push_back(macc(1'b1, 32'h10, 32'hCD000000, 4'b1000));
        mem_q.push_back(macc(1'b1, 32'h14, 32'h000000AB, 4'b0001));
        issue(1'b1, 3'b001, 32'h13, 32'h0000ABCD, 1'b1, rsp(2'd3, 1'b0, 32'h0));
        wait_idle();
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        mem_q.push_back(macc(1'b0, 32'h14, 32'h0, 4'b0000));
        issue(1'b0, 3'b101, 32'h13, 32'h0, 1'b1, rsp(2'd3, 1'b0, 32'h0000ABCD));
        wait_idle();
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        mem_q.push_back(macc(1'b0, 32'h14, 32'h0, 4'b0000));
        issue(1'b0, 3'b001, 32'h13, 32'h0, 1'b1, rsp(2'd3, 1'b0, 32'hFFFFABCD));
        wait_idle();

        // Byte store into lane 1 of 0xCDFF1234, then word read back.
        mem_q.push_back(macc(1'b1, 32'h10, 32'h00005A00, 4'b0010));
        issue(1'b1, 3'b000, 32'h11, 32'h0000005A, 1'b1, rsp(2'd2, 1'b0, 32'h0));
        wait_idle();
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rsp(2'd2, 1'b0, 32'hCDFF5A34));
        wait_idle();

        // Crossing word load with busy check across the whole transaction.
        poke(4'd3, 32'h44332211);
        poke(4'd4, 32'h88776655);
        mem_q.push_back(macc(1'b0, 32'h0C, 32'h0, 4'b0000));
        mem_q.push_back(macc(1'b0, 32'h10, 32'h0, 4'b0000));
        issue(1'b0, 3'b010, 32'h0E, 32'h0, 1'b1, rsp(2'd3, 1'b0, 32'h66554433));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_ready", {31'b0, req_ready}, 32'h0);
        end
        wait_idle();

        // Illegal types: no memory activity, error response one cycle after accept.
        issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, rsp(2'd1, 1'b1, 32'h0));
        wait_idle();
        issue(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b1, rsp(2'd1, 1'b1, 32'h0));
        wait_idle();

        // Reset during the first write of a crossing store.
        mem_q.push_back(macc(1'b1, 32'h0C, 32'h33440000, 4'b1100));
        issue(1'b1, 3'b010, 32'h0E, 32'h11223344, 1'b0, 35'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midop");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'b0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        check("midop_acc0_word", mem[3], 32'h33442211);
        check("midop_no_acc1", mem[4], 32'h88776655);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
